glip_packet_deframer: RTL and testbench
=======================================

GLIP_PACKET_DEFRAMER -- requirements
Module: glip_packet_deframer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: width of every data word.
REQ-002 SHALL have parameter DEST_WIDTH, default 8: width of the header destination field; LEN_WIDTH = WORD_WIDTH - DEST_WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port in_data, input, WORD_WIDTH: word from the upstream GLIP FIFO, fifo_in_data side.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: word is consumed on the cycle where in_valid and in_ready are both 1.
REQ-008 SHALL have port abort, input, 1: sampled synchronously; terminates the current packet.
REQ-009 SHALL have port out_data, output, WORD_WIDTH: payload word.
REQ-010 SHALL have port out_dest, output, DEST_WIDTH: destination of the packet that owns out_data.
REQ-011 SHALL have port out_first, output, 1: out_data is the first payload word of its packet.
REQ-012 SHALL have port out_last, output, 1: out_data is the last payload word of its packet.
REQ-013 SHALL have port out_valid, output, 1: output register holds a word.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts; transfer happens when out_valid and out_ready are both 1.
REQ-015 SHALL have port pkt_cnt, output, WORD_WIDTH: count of completed packets; wraps modulo 2^WORD_WIDTH.
REQ-016 SHALL have port err_empty, output, 1: one-cycle pulse when a zero-length header is consumed.
REQ-017 SHALL have port err_abort, output, 1: one-cycle pulse when an abort takes effect.

Function
REQ-018 SHALL decode each header word as dest = in_data[WORD_WIDTH-1:LEN_WIDTH] and len = in_data[LEN_WIDTH-1:0], with len being the number of payload words that follow.
REQ-019 SHALL implement the states HEADER, PAYLOAD and DISCARD.
REQ-020 In HEADER, in_ready SHALL be 1; a consumed header with len>0 SHALL latch dest, load remaining=len and go to PAYLOAD.
REQ-021 In HEADER, a consumed header with len=0 SHALL pulse err_empty, leave the state in HEADER and produce no output.
REQ-022 In PAYLOAD, in_ready SHALL be (~out_valid | out_ready), giving full throughput with one output register.
REQ-023 A payload word consumed in cycle n SHALL appear on out_data in cycle n+1 with the latched out_dest; out_first=1 when remaining==len, and out_last=1 when remaining==1.
REQ-024 Each consumed payload word SHALL decrement remaining; the consume with remaining==1 SHALL increment pkt_cnt and return the state to HEADER.
REQ-025 A header SHALL be acceptable in the cycle after the last payload consume, even while the last word still waits in the output register.
REQ-026 The output register SHALL hold its contents and flags stable while out_valid=1 and out_ready=0.
REQ-027 out_valid SHALL clear after a transfer unless a new word is loaded in the same cycle.
REQ-028 In PAYLOAD, abort=1 SHALL have priority over a simultaneous payload consume. The word is discarded and the following apply:
  - err_abort pulses;
  - pkt_cnt is not incremented;
  - if remaining>0 after the discarded word, the state goes to DISCARD; otherwise it goes to HEADER.
REQ-029 A word already in the output register when abort hits SHALL still be delivered unchanged.
REQ-030 In DISCARD, in_ready SHALL be 1, and each consumed word SHALL decrement remaining without output; the consume with remaining==1 SHALL return the state to HEADER.
REQ-031 abort SHALL be ignored in HEADER and DISCARD.
REQ-032 A zero-length header SHALL NOT alter out_dest or any word held in the output register.

Reset
REQ-033 While rst=0, the block SHALL apply the following values asynchronously:
  - state=HEADER, remaining=0;
  - out_valid=0, out_data=0, out_dest=0, out_first=0, out_last=0;
  - pkt_cnt=0, err_empty=0, err_abort=0.
REQ-034 Reset mid-packet SHALL drop the partial packet, with no output after release until a new header arrives.
REQ-035 After release, the first consumed word SHALL be treated as a header.

Verification
REQ-036 Header 0x0A03, then 0x1111, 0x2222, 0x3333 with out_ready=1 -> three outputs, each out_dest=0x0A; first/last flags 1/0, 0/0, 0/1; pkt_cnt=1; each word one cycle after its consume.
REQ-037 Same stream with out_ready=0 for 5 cycles after the first output -> out_data holds 0x1111 with flags stable and in_ready=0; no words lost or duplicated after release.
REQ-038 Header 0x0500 followed by header 0x0601 and 0xBEEF -> err_empty pulses once; single output 0xBEEF with dest 0x06 and first=last=1; pkt_cnt=1.
REQ-039 Header 0x0204, one payload word, then abort concurrent with the second payload word, then two more words -> first word delivered with last=0; err_abort pulses once; the remaining two words are consumed with no output; pkt_cnt=0; the next header is decoded normally.
REQ-040 rst=0 asserted after two of four payload words -> all outputs return to their reset values; after release, header 0x0301 and 0x00AA -> single output 0x00AA with dest 0x03.
REQ-041 pkt_cnt preloaded to 0xFFFF by sending 65535 one-word packets, then one more packet -> pkt_cnt wraps to 0x0000.

Source files
------------

// File: rtl/glip_packet_deframer.sv
// Splits a GLIP word stream into packets: header {dest,len} then len payload words.
// One registered output stage; abort drops the rest of the current packet.
module glip_packet_deframer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] pkt_cnt,
  output logic                  err_empty,
  output logic                  err_abort
);

  localparam int unsigned LEN_WIDTH = WORD_WIDTH - DEST_WIDTH;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;

  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                  err_empty_q, err_empty_d;
  logic                  err_abort_q, err_abort_d;

  logic                  in_ready_c;
  logic                  hdr_take, pay_take, abort_take, disc_take;
  logic [DEST_WIDTH-1:0] hdr_dest;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic                  last_word;

  assign hdr_dest  = in_data[WORD_WIDTH-1:LEN_WIDTH];
  assign hdr_len   = in_data[LEN_WIDTH-1:0];
  assign last_word = (remaining_q == LEN_WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HEADER;
      remaining_q <= '0;
      len_q       <= '0;
      dest_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      dest_q      <= dest_d;
    end
  end

  // Handshake and per-state consume strobes; abort only matters in PAYLOAD
  always_comb begin
    in_ready_c = 1'b0;
    hdr_take   = 1'b0;
    pay_take   = 1'b0;
    abort_take = 1'b0;
    disc_take  = 1'b0;
    case (state_q)
      ST_HEADER: begin
        in_ready_c = 1'b1;
        hdr_take   = in_valid;
      end
      ST_PAYLOAD: begin
        in_ready_c = ~out_valid_q | out_ready;
        abort_take = in_valid & in_ready_c & abort;
        pay_take   = in_valid & in_ready_c & ~abort;
      end
      ST_DISCARD: begin
        in_ready_c = 1'b1;
        disc_take  = in_valid;
      end
      default: ;
    endcase
  end

  // Next state and packet bookkeeping
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    dest_d      = dest_q;
    case (state_q)
      ST_HEADER: begin
        if (hdr_take && (hdr_len != '0)) begin
          dest_d      = hdr_dest;
          len_d       = hdr_len;
          remaining_d = hdr_len;
          state_d     = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pay_take || abort_take) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (last_word)       state_d = ST_HEADER;
          else if (abort_take) state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (disc_take) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (last_word) state_d = ST_HEADER;
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

  // Output stage: load on payload consume, hold while stalled
  always_comb begin
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (pay_take) begin
      out_data_d  = in_data;
      out_dest_d  = dest_q;
      out_first_d = (remaining_q == len_q);
      out_last_d  = last_word;
      out_valid_d = 1'b1;
    end
    pkt_cnt_d   = pkt_cnt_q + WORD_WIDTH'(pay_take & last_word);
    err_empty_d = hdr_take & (hdr_len == '0);
    err_abort_d = abort_take;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      err_empty_q <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_empty_q <= err_empty_d;
      err_abort_q <= err_abort_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_empty = err_empty_q;
  assign err_abort = err_abort_q;

endmodule

// File: tb/tb_glip_packet_deframer.sv
// Scoreboard bench for glip_packet_deframer: packet-level reference model,
// directed scenarios, randomized packets, and a narrow instance for counter wrap.
module tb_glip_packet_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] out_data;
  logic [7:0]  out_dest;
  logic        out_first, out_last, out_valid;
  logic        out_ready;
  logic [15:0] pkt_cnt;
  logic        err_empty, err_abort;

  logic [7:0]  s_in_data;
  logic        s_in_valid, s_in_ready;
  logic        s_abort;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [3:0]  s_out_dest;
  logic        s_out_first, s_out_last, s_out_valid;
  logic [7:0]  s_pkt_cnt;
  logic        s_err_empty, s_err_abort;

  always #5 clk = ~clk;

  glip_packet_deframer #(.WORD_WIDTH(16), .DEST_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .out_data(out_data), .out_dest(out_dest), .out_first(out_first),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .pkt_cnt(pkt_cnt),
    .err_empty(err_empty), .err_abort(err_abort)
  );

  glip_packet_deframer #(.WORD_WIDTH(8), .DEST_WIDTH(4)) u_dut_narrow (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .abort(s_abort), .out_data(s_out_data), .out_dest(s_out_dest), .out_first(s_out_first),
    .out_last(s_out_last), .out_valid(s_out_valid), .out_ready(s_out_ready), .pkt_cnt(s_pkt_cnt),
    .err_empty(s_err_empty), .err_abort(s_err_abort)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  dest;
    logic        first;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: position inside the current packet
  int          mstate;
  int          mpos, mlen;
  logic [7:0]  mdest;
  logic [15:0] mcnt;
  bit          exp_empty, exp_abort, pend;
  logic [15:0] pend_data;

  always @(negedge clk) begin
    if (!rst) begin
      mstate = 0; mpos = 0; mlen = 0; mdest = '0; mcnt = '0;
      exp_empty = 1'b0; exp_abort = 1'b0; pend = 1'b0;
      sb.delete();
    end else begin
      check("pkt_cnt", pkt_cnt, mcnt);
      check("err_empty", err_empty, exp_empty);
      check("err_abort", err_abort, exp_abort);
      if (pend) begin
        check("load_valid", out_valid, 1);
        check("load_data", out_data, pend_data);
      end
      if (mstate != 1) check("in_ready_idle", in_ready, 1);
      exp_empty = 1'b0; exp_abort = 1'b0; pend = 1'b0;
      if (in_valid && in_ready) begin
        case (mstate)
          0: begin
            if (in_data[7:0] == 8'd0) exp_empty = 1'b1;
            else begin
              mdest = in_data[15:8]; mlen = int'(in_data[7:0]); mpos = 0; mstate = 1;
            end
          end
          1: begin
            if (abort) begin
              exp_abort = 1'b1;
              mpos++;
              mstate = (mpos == mlen) ? 0 : 2;
            end else begin
              sb.push_back('{in_data, mdest, mpos == 0, mpos == mlen - 1});
              pend = 1'b1; pend_data = in_data;
              mpos++;
              if (mpos == mlen) begin mstate = 0; mcnt++; end
            end
          end
          default: begin
            mpos++;
            if (mpos == mlen) mstate = 0;
          end
        endcase
      end
    end
  end

  // Output monitor: every transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", out_valid, 0);
      else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_dest", out_dest, mon_e.dest);
        check("out_first", out_first, mon_e.first);
        check("out_last", out_last, mon_e.last);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_word(input logic [15:0] d, input logic ab);
    int guard = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; abort = ab;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      step();
      guard++;
      if (!done && guard > 200) begin
        check("handshake_timeout", in_ready, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0; abort = 1'b0; in_data = 16'($urandom);
  endtask

  task automatic send_small(input logic [7:0] d);
    int guard = 0;
    bit done = 1'b0;
    s_in_valid = 1'b1; s_in_data = d;
    while (!done) begin
      @(negedge clk);
      done = s_in_ready;
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 50) begin
        check("small_handshake_timeout", s_in_ready, 1);
        done = 1'b1;
      end
    end
    s_in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] len;
    logic [7:0] dest;
    rst = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    s_in_data = '0; s_in_valid = 1'b0; s_abort = 1'b0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_dest", out_dest, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err_empty", err_empty, 0);
    check("rst_err_abort", err_abort, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Counter wrap on the narrow instance: 255 packets, then one more
    for (int i = 0; i < 255; i++) begin
      send_small(8'h11);
      send_small(8'(i));
    end
    @(negedge clk);
    check("pkt_cnt_pre_wrap", s_pkt_cnt, 8'hFF);
    @(posedge clk); #1;
    send_small(8'h21);
    send_small(8'h5A);
    @(negedge clk);
    check("pkt_cnt_wrap", s_pkt_cnt, 8'h00);
    @(posedge clk); #1;

    // Basic three-word packet at full throughput
    send_word(16'h0A03, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    idle(2);
    check("pkt_cnt_basic", pkt_cnt, 1);

    // Backpressure: consumer stalls for 5 cycles after the first word
    out_ready = 1'b0;
    send_word(16'h0A03, 1'b0);
    send_word(16'h1111, 1'b0);
    in_valid = 1'b1; in_data = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 16'h1111);
      check("stall_out_first", out_first, 1);
      check("stall_out_last", out_last, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    idle(2);

    // Zero-length header followed by a one-word packet
    send_word(16'h0500, 1'b0);
    send_word(16'h0601, 1'b0);
    send_word(16'hBEEF, 1'b0);
    idle(2);

    // Abort on the second of four words, then a normal packet
    send_word(16'h0204, 1'b0);
    send_word(16'hA001, 1'b0);
    send_word(16'hA002, 1'b1);
    send_word(16'hA003, 1'b0);
    send_word(16'hA004, 1'b0);
    send_word(16'h0701, 1'b0);
    send_word(16'h1234, 1'b0);
    idle(2);

    // Reset in the middle of a packet
    send_word(16'h0904, 1'b0);
    send_word(16'hC001, 1'b0);
    send_word(16'hC002, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_dest", out_dest, 0);
    check("midrst_out_flags", {out_first, out_last}, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_errs", {err_empty, err_abort}, 0);
    idle(2);
    rst = 1'b1;
    idle(3);
    send_word(16'h0301, 1'b0);
    send_word(16'h00AA, 1'b0);
    idle(2);

    // Randomized packets with random gaps, aborts and backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      len  = 8'($urandom_range(0, 5));
      dest = 8'($urandom);
      send_word({dest, len}, ($urandom_range(0, 5) == 0));
      for (int w = 0; w < int'(len); w++) begin
        idle($urandom_range(0, 2));
        send_word(16'($urandom), ($urandom_range(0, 5) == 0));
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
